microcpu_exec_stage: RTL and testbench
======================================

# microcpu_exec_stage

Issue/writeback stage wrapped around the 16-bit ALU in the micro CPU. It accepts 16-bit instructions over a valid/ready handshake and holds a 16×16 register file. It drives the ALU's `a`, `b` and `func` inputs from a registered execute slot, captures the ALU result into a writeback register, and commits it to the register file one cycle later. It forwards results to the next instruction, counts retired instructions and flags illegal opcodes.

## Interface
- `RETIRE_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage can accept; equals `!stall`.
- `in_instr` in 16: instruction fields are `[15:12]` func, `[11:8]` rd, `[7:4]` rs1, `[3:0]` rs2.
- `stall` in 1: freeze the whole pipeline this cycle.
- `alu_a`, `alu_b` out 16: operands to the ALU.
- `alu_func` out 4: function code to the ALU.
- `alu_out` in 16: combinational ALU result.
- `wb_valid` out 1: writeback register holds a result.
- `wb_rd` out 4: destination of the writeback result.
- `wb_data` out 16: the writeback result.
- `dbg_raddr` in 4: debug read address.
- `dbg_rdata` out 16: combinational debug read of the register file; r0 reads 0.
- `retired` out RETIRE_W: count of committed instructions; wraps at the maximum value.
- `illegal` out 1: sticky flag, set when an illegal func is issued.

## Operation
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 MUL (low 16 bits), 4 AND, 5 OR, 15 LDI.
  - 6–14 are illegal.
- LDI:
  - Writes `{rs1,rs2}` zero-extended to 16 bits into rd.
  - Does not use the ALU; drives `alu_func`=0.
- Register r0 reads as 0. Writes to r0 are discarded but still count as retired.
- Execute (EX) slot: `ex_valid` plus the latched instruction.
  - An instruction is accepted at an edge where `in_valid && in_ready`.
  - An accepted instruction loads into EX.
  - If not accepted and `!stall`, `ex_valid` clears.
- Operand read for the EX instruction, for each of rs1 and rs2:
  - If rs == 0, the operand is 0.
  - Else if `wb_valid` and `wb_rd` == rs, the operand is `wb_data` (forwarding).
  - Otherwise the operand is the register file content.
- ALU drive:
  - While `ex_valid` holds an ALU opcode (0–5), `alu_func` = func, `alu_a` = op1, `alu_b` = op2.
  - Otherwise all three are 0.
- Writeback (WB) register, at an edge with `!stall`:
  - `wb_valid` ← `ex_valid` && func ∈ {1..5, 15}.
  - `wb_rd` ← rd.
  - `wb_data` ← `alu_out`, or the immediate for LDI.
  - NOP and illegal opcodes do not produce a WB entry.
- Commit, at an edge with `wb_valid && !stall`:
  - Register file [`wb_rd`] ← `wb_data`, unless `wb_rd` == 0.
  - `retired` increments.
- Illegal opcode: at an edge with `!stall` and `ex_valid` with func 6–14, `illegal` sets. It stays set until reset.
- Stall: EX, WB, the register file, `retired` and `illegal` all hold. `in_ready` = 0.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - `ex_valid`=0 and `wb_valid`=0.
  - `wb_rd`=0, `wb_data`=0.
  - All registers =0, `retired`=0, `illegal`=0.
  - Hence `alu_a`/`alu_b`/`alu_func`=0, and `in_ready` follows `stall`.
- Reset mid-operation: in-flight EX/WB contents are discarded and nothing commits.
- Latency, for an instruction accepted at edge N:
  - It drives the ALU during cycle N→N+1.
  - `wb_valid` is visible after edge N+1.
  - The register file is updated at edge N+2, absent stalls.
  - Each stalled cycle adds exactly one cycle.
- Throughput: one instruction per cycle.
- Dependences: back-to-back dependent instructions need no bubble.
  - Distance 1 is resolved by forwarding.
  - Distance 2 reads the already-committed register file, because the write occurs at the same edge the instruction entered EX.
- Simultaneous commit and debug read of the same address: `dbg_rdata` shows the old value until the edge.
- Counter wrap: `retired` wraps from 2^RETIRE_W−1 to 0.

## Test plan
- Reset, then LDI r1,0x12; LDI r2,0x34; ADD r3,r1,r2 issued back-to-back:
  - `alu_a`=0x0012 and `alu_b`=0x0034 during the ADD's EX cycle.
  - `dbg_rdata`(r3)=0x0046 two edges after ADD acceptance.
  - `retired`=3.
- Forwarding chain: LDI r1,0xFF; MUL r1,r1,r1; SUB r2,r1,r1:
  - The MUL result 0xFE01 is forwarded, so SUB sees a=b=0xFE01.
  - r2=0.
- Stall: hold `stall` high for 3 cycles with ADD in EX:
  - `in_ready`=0.
  - `wb_valid`, `wb_data` and `retired` remain constant.
  - The result commits exactly 3 cycles later than the unstalled case.
- Illegal/NOP: issue func=0x7 then func=0x0:
  - `illegal` rises one edge after the 0x7 enters EX.
  - No WB entries; `retired` unchanged.
  - `illegal` stays 1 through subsequent legal traffic.
- r0 and wrap:
  - LDI r0,0xAB leaves r0 reading 0 but increments `retired`.
  - With RETIRE_W=2, four commits return `retired` to 0.
- Async reset mid-stream: drop `rst_n` between clock edges while WB is valid:
  - All outputs go to 0 immediately.
  - The pending write is lost; the register read returns 0.

Source files
------------

// File: rtl/microcpu_exec_stage.sv
// Issue/writeback stage around the external 16-bit ALU: one execute slot, one
// writeback register, a 16x16 register file with r0 hard-wired to zero.
module microcpu_exec_stage #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_instr,
    input  logic                stall,
    output logic [15:0]         alu_a,
    output logic [15:0]         alu_b,
    output logic [3:0]          alu_func,
    input  logic [15:0]         alu_out,
    output logic                wb_valid,
    output logic [3:0]          wb_rd,
    output logic [15:0]         wb_data,
    input  logic [3:0]          dbg_raddr,
    output logic [15:0]         dbg_rdata,
    output logic [RETIRE_W-1:0] retired,
    output logic                illegal
);

    // Handshake: an instruction transfers at a rising edge where
    // in_valid && in_ready; in_ready is simply !stall.
    logic                ex_valid_q, ex_valid_d;
    logic [15:0]         ex_instr_q, ex_instr_d;
    logic                wb_valid_q, wb_valid_d;
    logic [3:0]          wb_rd_q, wb_rd_d;
    logic [15:0]         wb_data_q, wb_data_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                illegal_q, illegal_d;
    logic [15:0]         rf_q [16];

    logic [3:0]  ex_func, ex_rd, ex_rs1, ex_rs2;
    logic        ex_is_alu, ex_is_ldi, ex_writes, ex_illegal;
    logic [15:0] op1, op2;

    assign ex_func    = ex_instr_q[15:12];
    assign ex_rd      = ex_instr_q[11:8];
    assign ex_rs1     = ex_instr_q[7:4];
    assign ex_rs2     = ex_instr_q[3:0];
    assign ex_is_alu  = (ex_func <= 4'd5);
    assign ex_is_ldi  = (ex_func == 4'd15);
    assign ex_writes  = ((ex_func >= 4'd1) && (ex_func <= 4'd5)) || ex_is_ldi;
    assign ex_illegal = (ex_func >= 4'd6) && (ex_func <= 4'd14);

    assign in_ready = !stall;

    // The WB entry has not reached the register file yet, so it wins over it.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (ex_rs1 != 4'd0) begin
            op1 = (wb_valid_q && (wb_rd_q == ex_rs1)) ? wb_data_q : rf_q[ex_rs1];
        end
        if (ex_rs2 != 4'd0) begin
            op2 = (wb_valid_q && (wb_rd_q == ex_rs2)) ? wb_data_q : rf_q[ex_rs2];
        end
    end

    always_comb begin
        alu_func = '0;
        alu_a    = '0;
        alu_b    = '0;
        if (ex_valid_q && ex_is_alu) begin
            alu_func = ex_func;
            alu_a    = op1;
            alu_b    = op2;
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_instr_d = ex_instr_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        retired_d  = retired_q;
        illegal_d  = illegal_q;
        if (!stall) begin
            ex_valid_d = in_valid;
            if (in_valid) begin
                ex_instr_d = in_instr;
            end
            wb_valid_d = ex_valid_q && ex_writes;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_is_ldi ? {8'h00, ex_rs1, ex_rs2} : alu_out;
            if (wb_valid_q) begin
                retired_d = retired_q + RETIRE_W'(1);
            end
            if (ex_valid_q && ex_illegal) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
        end
    end

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (!stall && wb_valid_q && (wb_rd_q != 4'd0)) begin
            rf_q[wb_rd_q] <= wb_data_q;
        end
    end

    assign dbg_rdata = (dbg_raddr == 4'd0) ? 16'h0000 : rf_q[dbg_raddr];
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_microcpu_exec_stage.sv
// Bench for microcpu_exec_stage: an in-order ISA model supplies operand and
// result expectations; a second instance with a 2-bit counter covers wrap.
module tb_microcpu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        stall;
    logic [3:0]  dbg_raddr;

    logic        in_ready, wb_valid, illegal;
    logic [15:0] alu_a, alu_b, alu_out, wb_data, dbg_rdata;
    logic [3:0]  alu_func, wb_rd;
    logic [15:0] retired;

    logic        in_ready2, wb_valid2, illegal2;
    logic [15:0] alu_a2, alu_b2, alu_out2, wb_data2, dbg_rdata2;
    logic [3:0]  alu_func2, wb_rd2;
    logic [1:0]  retired2;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (f)
            4'd1:    r = a + b;
            4'd2:    r = a - b;
            4'd3:    r = a * b;
            4'd4:    r = a & b;
            4'd5:    r = a | b;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    assign alu_out  = alu_fn(alu_func, alu_a, alu_b);
    assign alu_out2 = alu_fn(alu_func2, alu_a2, alu_b2);

    microcpu_exec_stage #(.RETIRE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .stall(stall), .alu_a(alu_a), .alu_b(alu_b),
        .alu_func(alu_func), .alu_out(alu_out), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .retired(retired), .illegal(illegal)
    );

    microcpu_exec_stage #(.RETIRE_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .stall(stall), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_func(alu_func2), .alu_out(alu_out2), .wb_valid(wb_valid2), .wb_rd(wb_rd2),
        .wb_data(wb_data2), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata2),
        .retired(retired2), .illegal(illegal2)
    );

    // Reference state: arch_rf is the in-order result of every issued
    // instruction; crf is what the register file should hold right now.
    logic [15:0] arch_rf [16];
    logic [15:0] crf [16];
    logic [19:0] exp_q [$];
    logic        m_ex_v, m_ex_writes, m_ex_ill, m_wbv, m_ill;
    logic [3:0]  m_ex_func;
    logic [15:0] m_ex_a, m_ex_b;
    int unsigned m_ret;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] f, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        return {f, rd, rs1, rs2};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            arch_rf[i] = '0;
            crf[i]     = '0;
        end
        exp_q.delete();
        m_ex_v = 1'b0; m_ex_writes = 1'b0; m_ex_ill = 1'b0;
        m_ex_func = '0; m_ex_a = '0; m_ex_b = '0;
        m_wbv = 1'b0; m_ill = 1'b0; m_ret = 0;
    endtask

    task automatic issue(input logic [15:0] instr);
        logic [3:0]  f, rd, rs1, rs2;
        logic [15:0] a, b, res;
        f = instr[15:12]; rd = instr[11:8]; rs1 = instr[7:4]; rs2 = instr[3:0];
        a = (rs1 == 4'd0) ? 16'h0000 : arch_rf[rs1];
        b = (rs2 == 4'd0) ? 16'h0000 : arch_rf[rs2];
        m_ex_func   = f;
        m_ex_a      = a;
        m_ex_b      = b;
        m_ex_writes = ((f >= 4'd1) && (f <= 4'd5)) || (f == 4'd15);
        m_ex_ill    = (f >= 4'd6) && (f <= 4'd14);
        res = (f == 4'd15) ? {8'h00, rs1, rs2} : alu_fn(f, a, b);
        if (m_ex_writes) begin
            exp_q.push_back({rd, res});
            if (rd != 4'd0) arch_rf[rd] = res;
        end
    endtask

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic cycle(input logic v, input logic [15:0] instr, input logic st, input logic [3:0] ra);
        logic [19:0] e;
        logic        fire;
        in_valid = v; in_instr = instr; stall = st; dbg_raddr = ra;
        #1;
        check("in_ready", in_ready, !st);
        check("dbg_rdata", dbg_rdata, crf[ra]);
        @(posedge clk);
        if (!st) begin
            if (m_wbv) begin
                if (exp_q.size() == 0) begin
                    check("wb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_rd", wb_rd, e[19:16]);
                    check("wb_data", wb_data, e[15:0]);
                    if (e[19:16] != 4'd0) crf[e[19:16]] = e[15:0];
                end
                m_ret++;
            end
            if (m_ex_v && m_ex_ill) m_ill = 1'b1;
            m_wbv  = m_ex_v && m_ex_writes;
            m_ex_v = v;
            if (v) issue(instr);
        end
        @(negedge clk);
        fire = m_ex_v && (m_ex_func <= 4'd5);
        check("alu_func", alu_func, fire ? m_ex_func : 4'd0);
        check("alu_a", alu_a, fire ? m_ex_a : 16'h0000);
        check("alu_b", alu_b, fire ? m_ex_b : 16'h0000);
        check("wb_valid", wb_valid, m_wbv);
        check("retired", retired, m_ret[15:0]);
        check("retired_w2", retired2, m_ret[1:0]);
        check("illegal", illegal, m_ill);
    endtask

    task automatic idle(input int n, input logic [3:0] ra);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, ra);
    endtask

    task automatic peek(input string tag, input logic [3:0] ra, input logic [15:0] exp);
        dbg_raddr = ra;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    logic [3:0]  ftab [8];
    logic [3:0]  f;
    int unsigned ret_snap;

    initial begin
        ftab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15, 4'd15};
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; stall = 1'b1; dbg_raddr = 4'd3;
        #1;
        check("rst_in_ready_stall", in_ready, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_func", alu_func, 4'd0);
        check("rst_retired", retired, 16'h0000);
        check("rst_illegal", illegal, 1'b0);
        check("rst_dbg", dbg_rdata, 16'h0000);
        stall = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back LDI, LDI, dependent ADD
        cycle(1'b1, mk(4'd15, 4'd1, 4'h1, 4'h2), 1'b0, 4'd1);
        cycle(1'b1, mk(4'd15, 4'd2, 4'h3, 4'h4), 1'b0, 4'd2);
        cycle(1'b1, mk(4'd1, 4'd3, 4'd1, 4'd2), 1'b0, 4'd3);
        check("add_alu_a", alu_a, 16'h0012);
        check("add_alu_b", alu_b, 16'h0034);
        cycle(1'b0, 16'h0000, 1'b0, 4'd3);
        cycle(1'b0, 16'h0000, 1'b0, 4'd3);
        peek("add_r3", 4'd3, 16'h0046);
        check("add_retired", retired, 16'd3);

        // Forwarding chain through MUL
        cycle(1'b1, mk(4'd15, 4'd1, 4'hF, 4'hF), 1'b0, 4'd1);
        cycle(1'b1, mk(4'd3, 4'd1, 4'd1, 4'd1), 1'b0, 4'd1);
        cycle(1'b1, mk(4'd2, 4'd2, 4'd1, 4'd1), 1'b0, 4'd2);
        check("sub_alu_a", alu_a, 16'hFE01);
        check("sub_alu_b", alu_b, 16'hFE01);
        idle(3, 4'd1);
        peek("mul_r1", 4'd1, 16'hFE01);
        peek("sub_r2", 4'd2, 16'h0000);

        // Three stalled cycles with ADD in EX, then commit three cycles late
        cycle(1'b1, mk(4'd1, 4'd4, 4'd1, 4'd2), 1'b0, 4'd4);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(4'd4, 4'd5, 4'd1, 4'd1), 1'b1, 4'd4);
        cycle(1'b0, 16'h0000, 1'b0, 4'd4);
        peek("stall_r4_old", 4'd4, 16'h0000);
        cycle(1'b0, 16'h0000, 1'b0, 4'd4);
        peek("stall_r4_new", 4'd4, 16'hFE01);

        // Illegal opcode then NOP: sticky flag, no retirement
        ret_snap = m_ret;
        cycle(1'b1, mk(4'd7, 4'd6, 4'd1, 4'd2), 1'b0, 4'd6);
        check("ill_not_yet", illegal, 1'b0);
        cycle(1'b1, mk(4'd0, 4'd6, 4'd1, 4'd2), 1'b0, 4'd6);
        check("ill_set", illegal, 1'b1);
        idle(3, 4'd6);
        check("ill_nop_retired", retired, ret_snap[15:0]);
        peek("ill_r6", 4'd6, 16'h0000);

        // Write to r0 is dropped but retires
        ret_snap = m_ret;
        cycle(1'b1, mk(4'd15, 4'd0, 4'hA, 4'hB), 1'b0, 4'd0);
        idle(2, 4'd0);
        peek("r0_zero", 4'd0, 16'h0000);
        check("r0_retired", retired, ret_snap[15:0] + 16'd1);

        // Random traffic with random stalls
        for (int n = 0; n < 600; n++) begin
            f = ftab[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) f = 4'($urandom_range(6, 14));
            cycle(($urandom_range(0, 3) != 0), {f, 12'($urandom)},
                  ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));
        end
        idle(4, 4'($urandom_range(0, 15)));
        check("drain_queue", exp_q.size(), 32'd0);
        check("illegal_sticky", illegal, 1'b1);

        // Asynchronous reset between edges while WB holds LDI r5
        cycle(1'b1, mk(4'd15, 4'd5, 4'h7, 4'h7), 1'b0, 4'd5);
        cycle(1'b0, 16'h0000, 1'b0, 4'd5);
        check("pre_rst_wb_valid", wb_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wb_valid", wb_valid, 1'b0);
        check("arst_wb_data", wb_data, 16'h0000);
        check("arst_retired", retired, 16'h0000);
        check("arst_illegal", illegal, 1'b0);
        check("arst_alu_b", alu_b, 16'h0000);
        check("arst_dbg_r5", dbg_rdata, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 4'd5);
        peek("post_rst_r5", 4'd5, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
